// File: rtl/dcache_assoc_array.sv
// dcache_assoc_array
// N-way set-associative tag/data array for the L1 data cache with true-LRU
// replacement. A lookup uses the array contents at the start of the request
// cycle. The result, including the victim on a miss, is registered and
// presented one cycle later. Updates land at the same edge that ends the
// request cycle.

module dcache_assoc_array #(
   parameter int SETS   = 16,
   parameter int WAYS   = 2,
   parameter int TAG_W  = 23,
   parameter int LINE_W = 256,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              write_i,
   input  logic              dirty_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              ack_o,
   output logic              hit_o,
   output logic [WAY_W-1:0]  way_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic [LINE_W-1:0] data_o,
   output logic              valid_o,
   output logic              dirty_o
);

   // Storage. Tag and data are plain RAM with no reset. Valid, dirty and
   // age are reset. For each way, age is its recency rank: 0 is the most
   // recently used way and WAYS-1 is the least recently used way.
   logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
   logic [LINE_W-1:0] r_data  [SETS][WAYS];
   logic [WAYS-1:0]   r_valid [SETS];
   logic [WAYS-1:0]   r_dirty [SETS];
   logic [WAY_W-1:0]  r_age   [SETS][WAYS];

   logic              w_hit;
   logic [WAY_W-1:0]  w_hitWay;
   logic              w_anyInvalid;
   logic [WAY_W-1:0]  w_invWay;
   logic [WAY_W-1:0]  w_lruWay;
   logic [WAY_W-1:0]  w_victim;
   logic [WAY_W-1:0]  w_way;
   logic              w_touch;
   logic [WAY_W-1:0]  w_newAge [WAYS];

   // Tag match across the addressed set. The scan runs from the highest way
   // to the lowest, so the lowest matching way wins if several ways match.
   always_comb begin
      w_hit    = 1'b0;
      w_hitWay = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_valid[addr_i][w] && (r_tag[addr_i][w] == tag_i)) begin
            w_hit    = 1'b1;
            w_hitWay = WAY_W'(w);
         end
      end
   end

   // Victim choice. The lowest-index invalid way is preferred. If every way
   // is valid, the victim is the way whose age marks it least recently used.
   always_comb begin
      w_anyInvalid = 1'b0;
      w_invWay     = '0;
      w_lruWay     = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!r_valid[addr_i][w]) begin
            w_anyInvalid = 1'b1;
            w_invWay     = WAY_W'(w);
         end
         if (r_age[addr_i][w] == WAY_W'(WAYS - 1)) begin
            w_lruWay = WAY_W'(w);
         end
      end
      w_victim = w_anyInvalid ? w_invWay : w_lruWay;
      w_way    = w_hit ? w_hitWay : w_victim;
      w_touch  = req_i && (w_hit || write_i);
   end

   // Recency update for the selected way. Every way that was more recent
   // than the selected way moves one step older. The selected way becomes
   // age 0. The ages therefore stay a permutation.
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         w_newAge[w] = r_age[addr_i][w];
         if (WAY_W'(w) == w_way) begin
            w_newAge[w] = '0;
         end else if (r_age[addr_i][w] < r_age[addr_i][w_way]) begin
            w_newAge[w] = r_age[addr_i][w] + 1'b1;
         end
      end
   end

   // Valid, dirty and age state. Reset wins over any request in the same
   // cycle. A read miss leaves this state untouched.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               r_age[s][w] <= WAY_W'(w);
            end
         end
      end else if (req_i) begin
         if (w_touch) begin
            for (int w = 0; w < WAYS; w++) begin
               r_age[addr_i][w] <= w_newAge[w];
            end
         end
         if (write_i) begin
            r_valid[addr_i][w_way] <= 1'b1;
            r_dirty[addr_i][w_way] <= w_hit ? 1'b1 : dirty_i;
         end
      end
   end

   // Tag and data writes for a write hit or an allocation on a write miss.
   // On a hit, the stored tag already equals tag_i, so rewriting it is harmless.
   always_ff @(posedge clk_i) begin
      if (!rst_i && req_i && write_i) begin
         r_tag[addr_i][w_way]  <= tag_i;
         r_data[addr_i][w_way] <= data_i;
      end
   end

   // Registered result. Every field reports the selected way as it was
   // before this request's update. The one exception is data_o on a write
   // hit, which echoes the written line. Fields hold until the next request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_o   <= 1'b0;
         hit_o   <= 1'b0;
         way_o   <= '0;
         tag_o   <= '0;
         data_o  <= '0;
         valid_o <= 1'b0;
         dirty_o <= 1'b0;
      end else if (req_i) begin
         ack_o   <= 1'b1;
         hit_o   <= w_hit;
         way_o   <= w_way;
         tag_o   <= w_hit ? tag_i : r_tag[addr_i][w_way];
         data_o  <= (w_hit && write_i) ? data_i : r_data[addr_i][w_way];
         valid_o <= r_valid[addr_i][w_way];
         dirty_o <= r_dirty[addr_i][w_way];
      end else begin
         ack_o   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dcache_assoc_array.sv
// tb_dcache_assoc_array
// Directed bench for the associative array, configured with 4 ways. The
// reference model keeps a most-recent-first list of ways for each set and
// checks every DUT output on every cycle. Literal checks after each request
// pin the expected values of the directed scenarios.

module tb_dcache_assoc_array;

   localparam int SETS   = 16;
   localparam int WAYS   = 4;
   localparam int TAG_W  = 23;
   localparam int LINE_W = 256;
   localparam int IDX_W  = 4;
   localparam int WAY_W  = 2;

   localparam logic [LINE_W-1:0] D_AA = {32{8'hAA}};
   localparam logic [LINE_W-1:0] D_1  = {8{32'h1111_2222}};
   localparam logic [LINE_W-1:0] D_2  = {8{32'h3333_4444}};
   localparam logic [LINE_W-1:0] D_3  = {8{32'h5A5A_0F0F}};

   logic              clk_i;
   logic              rst_i;
   logic              req_i;
   logic              write_i;
   logic              dirty_i;
   logic [IDX_W-1:0]  addr_i;
   logic [TAG_W-1:0]  tag_i;
   logic [LINE_W-1:0] data_i;
   logic              ack_o;
   logic              hit_o;
   logic [WAY_W-1:0]  way_o;
   logic [TAG_W-1:0]  tag_o;
   logic [LINE_W-1:0] data_o;
   logic              valid_o;
   logic              dirty_o;

   int checks   = 0;
   int failures = 0;

   dcache_assoc_array #(
      .SETS   (SETS),
      .WAYS   (WAYS),
      .TAG_W  (TAG_W),
      .LINE_W (LINE_W)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .write_i (write_i),
      .dirty_i (dirty_i),
      .addr_i  (addr_i),
      .tag_i   (tag_i),
      .data_i  (data_i),
      .ack_o   (ack_o),
      .hit_o   (hit_o),
      .way_o   (way_o),
      .tag_o   (tag_o),
      .data_o  (data_o),
      .valid_o (valid_o),
      .dirty_o (dirty_o)
   );

   // Free-running clock with a 10-unit period.
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                              input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model. Each set holds a recency list of ways, most recent
   // first. mKnown records whether the bench knows what a way's tag and data
   // slots contain.
   logic [TAG_W-1:0]  mTag   [SETS][WAYS];
   logic [LINE_W-1:0] mData  [SETS][WAYS];
   bit                mValid [SETS][WAYS];
   bit                mDirty [SETS][WAYS];
   bit                mKnown [SETS][WAYS];
   int                mru    [SETS][WAYS];

   bit                live = 1'b0;
   bit                eAck, eHit, eValid, eDirty, eKnown;
   logic [WAY_W-1:0]  eWay;
   logic [TAG_W-1:0]  eTag;
   logic [LINE_W-1:0] eData;
   int                ms, mw, mpos;
   bit                mh;

   initial begin
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++)
            mKnown[s][w] = 1'b0;
   end

   task automatic modelTouch(input int s, input int w);
      int p;
      p = 0;
      for (int i = 0; i < WAYS; i++)
         if (mru[s][i] == w) p = i;
      for (int i = p; i > 0; i--)
         mru[s][i] = mru[s][i-1];
      mru[s][0] = w;
   endtask

   // Compare process. At each edge it advances the model with the inputs
   // sampled at that edge. It then checks the registered DUT outputs just
   // after the edge.
   always @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
               mValid[s][w] = 1'b0;
               mDirty[s][w] = 1'b0;
               mru[s][w]    = w;
            end
         eAck = 0; eHit = 0; eWay = '0; eTag = '0; eData = '0;
         eValid = 0; eDirty = 0; eKnown = 1;
         live = 1'b1;
      end else if (live) begin
         if (req_i) begin
            ms = int'(addr_i);
            mh = 1'b0;
            mw = 0;
            for (int w = WAYS - 1; w >= 0; w--)
               if (mValid[ms][w] && mTag[ms][w] == tag_i) begin
                  mh = 1'b1;
                  mw = w;
               end
            if (!mh) begin
               mw = mru[ms][WAYS-1];
               for (int w = WAYS - 1; w >= 0; w--)
                  if (!mValid[ms][w]) mw = w;
            end
            eAck   = 1;
            eHit   = mh;
            eWay   = WAY_W'(mw);
            eValid = mValid[ms][mw];
            eDirty = mDirty[ms][mw];
            if (mh) begin
               eTag   = tag_i;
               eData  = write_i ? data_i : mData[ms][mw];
               eKnown = 1;
            end else begin
               eTag   = mTag[ms][mw];
               eData  = mData[ms][mw];
               eKnown = mKnown[ms][mw];
            end
            if (write_i) begin
               mTag[ms][mw]   = tag_i;
               mData[ms][mw]  = data_i;
               mValid[ms][mw] = 1'b1;
               mDirty[ms][mw] = mh ? 1'b1 : dirty_i;
               mKnown[ms][mw] = 1'b1;
            end
            if (mh || write_i) modelTouch(ms, mw);
         end else begin
            eAck = 0;
         end
      end
      #1;
      if (live) begin
         checkOutput("cmp_ack",   ack_o,   eAck);
         checkOutput("cmp_hit",   hit_o,   eHit);
         checkOutput("cmp_way",   way_o,   eWay);
         checkOutput("cmp_valid", valid_o, eValid);
         checkOutput("cmp_dirty", dirty_o, eDirty);
         if (eKnown) begin
            checkOutput("cmp_tag",  tag_o,  eTag);
            checkOutput("cmp_data", data_o, eData);
         end
      end
   end

   // Drive one request at a falling edge. Return at the next falling edge,
   // when the result of this request is visible.
   task automatic applyStimulus(input bit wr, input bit dty, input int set,
                                input logic [TAG_W-1:0] tag,
                                input logic [LINE_W-1:0] data);
      req_i   = 1'b1;
      write_i = wr;
      dirty_i = dty;
      addr_i  = IDX_W'(set);
      tag_i   = tag;
      data_i  = data;
      @(negedge clk_i);
   endtask

   task automatic idle();
      req_i   = 1'b0;
      write_i = 1'b0;
      dirty_i = 1'b0;
      @(negedge clk_i);
   endtask

   // Directed scenarios.
   initial begin
      rst_i = 1'b1; req_i = 1'b0; write_i = 1'b0; dirty_i = 1'b0;
      addr_i = '0; tag_i = '0; data_i = '0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      checkOutput("reset_ack", ack_o, 0);

      // Read after reset misses on way 0.
      applyStimulus(0, 0, 3, 23'h1, '0);
      checkOutput("t1_ack",   ack_o,   1);
      checkOutput("t1_hit",   hit_o,   0);
      checkOutput("t1_way",   way_o,   0);
      checkOutput("t1_valid", valid_o, 0);
      checkOutput("t1_dirty", dirty_o, 0);
      idle();
      checkOutput("t1_ack_drop", ack_o, 0);

      // A write miss allocates way 0. A read then hits it.
      applyStimulus(1, 0, 3, 23'h1, D_AA);
      checkOutput("t2_wr_hit", hit_o, 0);
      applyStimulus(0, 0, 3, 23'h1, '0);
      checkOutput("t2_hit",   hit_o,   1);
      checkOutput("t2_way",   way_o,   0);
      checkOutput("t2_data",  data_o,  D_AA);
      checkOutput("t2_dirty", dirty_o, 0);
      idle();

      // Fill set 5 with tags A..D, touch A, then evict B with E.
      applyStimulus(1, 0, 5, 23'hA, D_1);
      applyStimulus(1, 0, 5, 23'hB, D_2);
      applyStimulus(1, 0, 5, 23'hC, D_3);
      applyStimulus(1, 0, 5, 23'hD, D_AA);
      checkOutput("t3_fill_way", way_o, 3);
      applyStimulus(0, 0, 5, 23'hA, '0);
      checkOutput("t3_readA_hit", hit_o, 1);
      applyStimulus(1, 0, 5, 23'hE, D_3);
      checkOutput("t3_evict_hit",   hit_o,   0);
      checkOutput("t3_evict_way",   way_o,   1);
      checkOutput("t3_evict_tag",   tag_o,   23'hB);
      checkOutput("t3_evict_valid", valid_o, 1);
      applyStimulus(0, 0, 5, 23'hA, '0);
      checkOutput("t3_A_kept_hit",  hit_o,   1);
      checkOutput("t3_A_kept_way",  way_o,   0);
      checkOutput("t3_A_kept_data", data_o,  D_1);
      applyStimulus(0, 0, 5, 23'hB, '0);
      checkOutput("t3_B_gone_hit", hit_o, 0);
      checkOutput("t3_B_gone_way", way_o, 2);
      checkOutput("t3_B_gone_tag", tag_o, 23'hC);
      idle();

      // A write hit makes a clean line dirty. Evicting it later reports
      // the old line for writeback.
      applyStimulus(1, 0, 7, 23'h10, D_1);
      applyStimulus(1, 0, 7, 23'h10, D_2);
      checkOutput("t4_wh_hit",   hit_o,   1);
      checkOutput("t4_wh_dirty", dirty_o, 0);
      checkOutput("t4_wh_data",  data_o,  D_2);
      applyStimulus(1, 0, 7, 23'h11, D_1);
      applyStimulus(1, 0, 7, 23'h12, D_1);
      applyStimulus(1, 0, 7, 23'h13, D_1);
      applyStimulus(1, 1, 7, 23'h14, D_3);
      checkOutput("t4_ev_way",   way_o,   0);
      checkOutput("t4_ev_valid", valid_o, 1);
      checkOutput("t4_ev_dirty", dirty_o, 1);
      checkOutput("t4_ev_tag",   tag_o,   23'h10);
      checkOutput("t4_ev_data",  data_o,  D_2);
      idle();

      // Back-to-back requests: a write is followed directly by a read of the same line.
      applyStimulus(1, 0, 0, 23'h7, D_3);
      applyStimulus(0, 0, 0, 23'h7, '0);
      checkOutput("t5_hit",  hit_o,  1);
      checkOutput("t5_way",  way_o,  0);
      checkOutput("t5_data", data_o, D_3);
      idle();

      // A reset that coincides with a request drops the request and clears all state.
      rst_i = 1'b1;
      applyStimulus(1, 1, 0, 23'h20, D_1);
      rst_i = 1'b0;
      checkOutput("t6_ack",   ack_o,   0);
      checkOutput("t6_hit",   hit_o,   0);
      checkOutput("t6_way",   way_o,   0);
      checkOutput("t6_tag",   tag_o,   0);
      checkOutput("t6_data",  data_o,  0);
      checkOutput("t6_valid", valid_o, 0);
      checkOutput("t6_dirty", dirty_o, 0);
      applyStimulus(0, 0, 5, 23'hA, '0);
      checkOutput("t6_rdA_hit",   hit_o,   0);
      checkOutput("t6_rdA_way",   way_o,   0);
      checkOutput("t6_rdA_valid", valid_o, 0);
      checkOutput("t6_rdA_tag",   tag_o,   23'hA);
      applyStimulus(0, 0, 0, 23'h7, '0);
      checkOutput("t6_rd7_hit", hit_o, 0);
      checkOutput("t6_rd7_way", way_o, 0);
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog that guarantees the run terminates.
   initial begin
      #100000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
